// File: rtl/tagged_pkg.sv
// Shared types and constants for the tagged array scheduler.
// Latency: none (declarations only).
// Backpressure: not applicable.
package tagged_pkg;

  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int DW    = 3;

  // Entry confidentiality tag; also used as the requester's domain.
  typedef enum logic {
    TAG_L = 1'b0,
    TAG_H = 1'b1
  } tag_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SCRUB = 1'b1
  } sched_state_t;

  // Phase bit values: even cycles belong to the low side, odd to the high side.
  localparam logic SLOT_L = 1'b0;
  localparam logic SLOT_H = 1'b1;

endpackage

// File: rtl/tag_access_check.sv
// Decides whether a domain may perform a read or write on an entry with a given tag.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module tag_access_check
  import tagged_pkg::*;
(
  input  tag_t dom,
  input  logic we,
  input  tag_t entry_tag,
  output logic allow,
  output logic denied
);

  // Writes only into the writer's own domain; reads only at or below the reader's level.
  always_comb begin
    allow  = we ? (entry_tag == dom) : ((dom == TAG_H) || (entry_tag == TAG_L));
    denied = ~allow;
  end

endmodule

// File: rtl/tagged_array_sched.sv
// Time-division scheduler over a 16-entry tagged array: even cycles low side, odd cycles high side.
// Latency: ack/denied/rdata registered, 1 cycle after the serving slot; high side never stalls.
// Backpressure: low requests wait behind scrub and cfg (held until ack); cfg held until cfg_ready.
module tagged_array_sched
  import tagged_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          lo_req,
  input  logic          lo_we,
  input  logic [AW-1:0] lo_addr,
  input  logic [DW-1:0] lo_wdata,
  output logic          lo_ack,
  output logic          lo_denied,
  output logic [DW-1:0] lo_rdata,
  input  logic          hi_req,
  input  logic          hi_we,
  input  logic [AW-1:0] hi_addr,
  input  logic [DW-1:0] hi_wdata,
  output logic          hi_ack,
  output logic          hi_denied,
  output logic [DW-1:0] hi_rdata,
  input  logic          cfg_valid,
  input  logic          cfg_tag,
  input  logic [AW-1:0] cfg_addr,
  input  logic          cfg_scrub_all,
  output logic          cfg_ready,
  output logic          busy
);

  localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

  logic          phase;
  sched_state_t  state;
  sched_state_t  state_nxt;
  logic [AW-1:0] ptr;

  tag_t          tag_q  [DEPTH];
  logic [DW-1:0] data_q [DEPTH];

  logic l_slot;
  logic h_slot;
  logic scrub_step;
  logic scrub_start;
  logic cfg_go;
  logic lo_go;
  logic hi_go;
  tag_t lo_tag;
  tag_t hi_tag;
  logic lo_allow;
  logic lo_block;
  logic hi_allow;
  logic hi_block;

  // Slot arbitration: the slot owner depends only on the phase bit, never on requests.
  always_comb begin
    l_slot      = (phase == SLOT_L);
    h_slot      = (phase == SLOT_H);
    scrub_step  = l_slot && (state == SCRUB);
    scrub_start = l_slot && (state == IDLE) && cfg_scrub_all;
    cfg_go      = l_slot && (state == IDLE) && !cfg_scrub_all && cfg_valid;
    lo_go       = l_slot && (state == IDLE) && !cfg_scrub_all && !cfg_valid && lo_req;
    hi_go       = h_slot && hi_req;
    lo_tag      = tag_q[lo_addr];
    hi_tag      = tag_q[hi_addr];
    cfg_ready   = scrub_start || cfg_go;
    busy        = (state == SCRUB);
  end

  tag_access_check u_lo_check (
    .dom       (TAG_L),
    .we        (lo_we),
    .entry_tag (lo_tag),
    .allow     (lo_allow),
    .denied    (lo_block)
  );

  tag_access_check u_hi_check (
    .dom       (TAG_H),
    .we        (hi_we),
    .entry_tag (hi_tag),
    .allow     (hi_allow),
    .denied    (hi_block)
  );

  // Next state: scrub runs from a start request until the last entry has been cleared.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (scrub_start) state_nxt = SCRUB;
      SCRUB:   if (scrub_step && (ptr == LAST_PTR)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Phase, FSM state and scrub pointer; the pointer wraps to 0 on its final increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase <= SLOT_L;
      state <= IDLE;
      ptr   <= '0;
    end else begin
      phase <= ~phase;
      state <= state_nxt;
      if (scrub_start) begin
        ptr <= '0;
      end else if (scrub_step) begin
        ptr <= ptr + 1'b1;
      end
    end
  end

  // Array writes: at most one low-side and one high-side source, never in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        tag_q[i]  <= TAG_L;
        data_q[i] <= '0;
      end
    end else begin
      if (scrub_step) begin
        tag_q[ptr]  <= TAG_L;
        data_q[ptr] <= '0;
      end else if (cfg_go) begin
        if (cfg_tag) begin
          tag_q[cfg_addr] <= TAG_H;
        end else if (tag_q[cfg_addr] == TAG_H) begin
          // Declassification wipes the contents so no high data becomes low-visible.
          tag_q[cfg_addr]  <= TAG_L;
          data_q[cfg_addr] <= '0;
        end
      end else if (lo_go && lo_we && lo_allow) begin
        data_q[lo_addr] <= lo_wdata;
      end
      if (hi_go && hi_we && hi_allow) begin
        data_q[hi_addr] <= hi_wdata;
      end
    end
  end

  // Registered completion: refused reads and all writes return zero data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lo_ack    <= 1'b0;
      lo_denied <= 1'b0;
      lo_rdata  <= '0;
      hi_ack    <= 1'b0;
      hi_denied <= 1'b0;
      hi_rdata  <= '0;
    end else begin
      lo_ack    <= lo_go;
      lo_denied <= lo_go && lo_block;
      lo_rdata  <= (lo_go && !lo_we && lo_allow) ? data_q[lo_addr] : '0;
      hi_ack    <= hi_go;
      hi_denied <= hi_go && hi_block;
      hi_rdata  <= (hi_go && !hi_we && hi_allow) ? data_q[hi_addr] : '0;
    end
  end

endmodule

// File: doc/tagged_array_sched.md
# tagged_array_sched

Time-division scheduler that shares one 16-entry tagged data array between a low-confidentiality requester, a high-confidentiality requester and a low-domain tag configuration port. Each entry carries a 1-bit tag: 0 = L, 1 = H. The tag sets which domain may write the entry and whether the low side may read it. Slot assignment is fixed and independent of any request, so high-side activity never changes low-side timing. The block owns the array storage and sits between the two requester pipelines and the array.

## Interface
- DEPTH, 16, number of entries
- AW, 4, address width (log2 DEPTH)
- DW, 3, data width
- clk  in  1  clock, label {L}
- rst_n  in  1  asynchronous active-low reset, label {L}
- lo_req / lo_we  in  1 / 1  low request valid, write enable {L}
- lo_addr / lo_wdata  in  AW / DW  low address, write data {L}
- lo_ack / lo_denied  out  1 / 1  low completion pulse, access refused {L}
- lo_rdata  out  DW  low read data, valid with lo_ack {L}
- hi_req / hi_we  in  1 / 1  high request valid, write enable {H}
- hi_addr / hi_wdata  in  AW / DW  high address, write data {H}
- hi_ack / hi_denied  out  1 / 1  high completion pulse, access refused {H}
- hi_rdata  out  DW  high read data, valid with hi_ack {H}
- cfg_valid / cfg_tag  in  1 / 1  retag request, new tag {L}
- cfg_addr  in  AW  entry to retag {L}
- cfg_scrub_all  in  1  start a full scrub {L}
- cfg_ready  out  1  configuration accepted this cycle {L}
- busy  out  1  scrub in progress {L}

## Operation
- Phase bit toggles every cycle after reset. Phase 0 is the L slot. Phase 1 is the H slot.
- L slot priority, highest first: scrub step, then cfg_valid, then lo_req. A request that loses waits and stays asserted with stable fields until its ack.
- cfg retag L->H: only the tag flips. cfg retag H->L: the tag clears and the data zeroes in the same write. cfg_ready pulses in the L slot in which the cfg is applied.
- cfg_scrub_all while IDLE:
  - Enters SCRUB. The pointer starts at 0.
  - Each L slot writes data = 0 and tag = L at the pointer, then increments the pointer.
  - After entry DEPTH-1, returns to IDLE.
  - busy is 1 throughout SCRUB.
  - cfg_valid, cfg_scrub_all and lo_req are not served during SCRUB. cfg_ready stays 0.
- Low accesses:
  - Write to an L entry is performed.
  - Write to an H entry is dropped, with lo_denied = 1.
  - Read of an L entry returns the data.
  - Read of an H entry returns 0, with lo_denied = 1.
- High accesses, served in every H slot including during SCRUB:
  - Any read is allowed.
  - Write to an H entry is performed.
  - Write to an L entry is dropped, with hi_denied = 1. H data never enters an L entry.
- Tags are written only by reset, cfg and scrub, all of which are L-domain sources.

## Timing
- Reset values: phase 0, FSM IDLE, all tags L, all data 0, every ack/denied/ready/busy output 0, rdata 0.
- Reset is asynchronous. Asserting it mid-scrub or with requests pending aborts everything, and nothing is replayed.
- A slot's operation is sampled and written at the clock edge ending that slot. ack, denied and rdata are registered, so they appear the cycle after the slot and last 1 cycle.
- Low latency from lo_req to lo_ack:
  - 1 cycle when lo_req rises in an L slot.
  - 2 cycles when it rises in an H slot.
  - Longer behind cfg or SCRUB, 2 cycles per lost slot.
- High latency is 1 or 2 cycles and is never stalled.
- A scrub takes exactly 2*DEPTH cycles. busy deasserts the cycle after the final scrub write.
- cfg and an H write to the same entry land in different slots, so the later slot sees the earlier result.
- The pointer wraps only on SCRUB exit, and the width is AW.

## Structure
- Shared package tagged_pkg holds:
  - tag_t, with TAG_L = 0 and TAG_H = 1.
  - sched_state_t, with IDLE and SCRUB.
  - the slot constants.
- One sub-module, tag_access_check, is combinational: inputs are domain, we and entry tag; outputs are allow and denied. It is instantiated once per slot.

## Test plan
- Reset, then low write 5 to addr 3, then low read addr 3 -> lo_rdata = 5, lo_denied = 0. busy = 0 and all tags are L after reset.
- cfg retag addr 3 to H, high write 6 -> low read addr 3 returns 0 with lo_denied = 1. High read returns 6.
- High write 7 to L entry 4 -> hi_denied = 1 and entry 4 is unchanged. A high read of entry 4 succeeds.
- Retag addr 3 H->L -> a low read returns 0, with no denied.
- cfg_scrub_all with continuous lo_req and hi_req:
  - busy stays high for 32 cycles and no lo_ack occurs.
  - hi_ack keeps its 2-cycle cadence.
  - Afterwards all entries are 0 and tagged L.
- Compare lo_ack timing with hi_req idle against hi_req saturated -> cycle-identical. Also assert rst_n low mid-scrub -> immediate return to the reset values.
